router_fsm: RTL and testbench

Packet-reception controller for the 1x3 router. Sits beside the synchronizer, FIFOs and input register and sequences one packet at a time: it decodes the 2-bit destination address, waits for the target FIFO to drain, drives the write enable through header, payload and parity bytes, stalls on FIFO full and returns to address decode. All outputs are Moore decodes of the state register. The synchronizer and register blocks consume them directly.

---
 rtl/router_fsm.sv | 132 +++++++++++++
 tb/tb_router_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: decodes the destination,
// sequences header/payload/parity writes and handles FIFO-full stalls.
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q;
    logic [1:0] empty_idx;
    logic       empty_sel;
    logic       soft_sel;
    logic       addr_ok;

    assign addr_ok = pkt_valid && (data_in != 2'd3);

    // While decoding, the address is still on data_in; afterwards only the latched copy is valid.
    assign empty_idx = (state_q == DECODE_ADDRESS) ? data_in : addr_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        empty_sel = 1'b0;
        soft_sel  = 1'b0;
        case (empty_idx)
            2'd0:    empty_sel = fifo_empty_0;
            2'd1:    empty_sel = fifo_empty_1;
            2'd2:    empty_sel = fifo_empty_2;
            default: empty_sel = 1'b0;
        endcase
        case (addr_q)
            2'd0:    soft_sel = soft_reset_0;
            2'd1:    soft_sel = soft_reset_1;
            2'd2:    soft_sel = soft_reset_2;
            default: soft_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == DECODE_ADDRESS && addr_ok)
                addr_q <= data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (addr_ok)
                    state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel)
                    state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    state_d = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // The selected channel's timeout abandons whatever packet is in flight.
        if (state_q != DECODE_ADDRESS && soft_sel)
            state_d = DECODE_ADDRESS;
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    assign busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus queues the expected output vector
// for each clock edge, a monitor pops and compares just after the edge.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Output vector order: detect_add lfd ld laf full rst_int write_enb busy
    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy};

    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_LFD = 8'b0100_0001;
    localparam logic [7:0] E_LD  = 8'b0010_0010;
    localparam logic [7:0] E_LAF = 8'b0001_0011;
    localparam logic [7:0] E_FUL = 8'b0000_1001;
    localparam logic [7:0] E_CPE = 8'b0000_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Monitor: one expectation per clock edge that stimulus announced.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, outs, e.val);
        end
    end

    // Inputs are set at a falling edge; the expected state after the next rising edge is queued.
    task automatic cyc(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        #2;
        check("reset_state", outs, E_DA);
        @(negedge clock);
        resetn = 1'b1;

        // Async reset while in LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'd0;
        cyc("rst_pkt_lfd", E_LFD);
        cyc("rst_pkt_ld", E_LD);
        #2 resetn = 1'b0;
        #1 check("rst_mid_ld", outs, E_DA);
        @(negedge clock);
        resetn = 1'b1; pkt_valid = 1'b0;
        cyc("rst_idle0", E_DA);
        cyc("rst_idle1", E_DA);

        // Clean packet to channel 1, three payload cycles
        pkt_valid = 1'b1; data_in = 2'd1;
        cyc("c1_lfd", E_LFD);
        cyc("c1_ld0", E_LD);
        cyc("c1_ld1", E_LD);
        cyc("c1_ld2", E_LD);
        pkt_valid = 1'b0;
        cyc("c1_lp", E_LP);
        cyc("c1_cpe", E_CPE);
        cyc("c1_da", E_DA);

        // Busy destination: channel 2 not empty, channel 1 (old addr) empty
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        cyc("wte0", E_WTE);
        pkt_valid = 1'b0;
        for (int i = 1; i < 5; i++) cyc($sformatf("wte%0d", i), E_WTE);
        fifo_empty_2 = 1'b1;
        cyc("wte_lfd", E_LFD);
        pkt_valid = 1'b1;
        cyc("wte_ld", E_LD);

        // Full stall: full and pkt_valid low together, full wins
        fifo_full = 1'b1; pkt_valid = 1'b0;
        cyc("full_prio", E_FUL);
        cyc("full_hold", E_FUL);
        fifo_full = 1'b0; low_pkt_valid = 1'b1;
        cyc("laf_a", E_LAF);
        cyc("laf_lp", E_LP);
        low_pkt_valid = 1'b0;
        cyc("laf_cpe", E_CPE);
        fifo_full = 1'b1;
        cyc("cpe_full", E_FUL);
        fifo_full = 1'b0; parity_done = 1'b1;
        cyc("laf_b", E_LAF);
        cyc("laf_pd_da", E_DA);
        parity_done = 1'b0;

        // LOAD_AFTER_FULL back to LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'd2;
        cyc("r_lfd", E_LFD);
        cyc("r_ld", E_LD);
        fifo_full = 1'b1;
        cyc("r_full", E_FUL);
        fifo_full = 1'b0;
        cyc("r_laf", E_LAF);
        cyc("r_laf_ld", E_LD);
        pkt_valid = 1'b0;
        cyc("r_lp", E_LP);
        cyc("r_cpe", E_CPE);
        cyc("r_da", E_DA);

        // Address 3 is ignored and leaves addr_q alone
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) cyc($sformatf("a3_%0d", i), E_DA);
        pkt_valid = 1'b0;
        check("a3_addr_q", {6'd0, dut.addr_q}, 8'd2);

        // Soft reset on channel 0 packet
        pkt_valid = 1'b1; data_in = 2'd0;
        cyc("s_lfd", E_LFD);
        cyc("s_ld", E_LD);
        soft_reset_1 = 1'b1;
        cyc("s_other0", E_LD);
        cyc("s_other1", E_LD);
        soft_reset_0 = 1'b1; fifo_full = 1'b1;
        cyc("s_sel_da", E_DA);
        soft_reset_1 = 1'b0; fifo_full = 1'b0;
        cyc("s_ign_da", E_LFD);
        cyc("s_lfd_da", E_DA);
        soft_reset_0 = 1'b0;

        // Soft reset out of WAIT_TILL_EMPTY on channel 1
        data_in = 2'd1; fifo_empty_1 = 1'b0;
        cyc("s_wte", E_WTE);
        pkt_valid = 1'b0; soft_reset_1 = 1'b1;
        cyc("s_wte_da", E_DA);
        soft_reset_1 = 1'b0; fifo_empty_1 = 1'b1;
        cyc("s_end", E_DA);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
